// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings and FSM state type for the load/store unit
//
// Purpose: funct3-style access size constants and the IDLE/WAIT state enum
//          used by load_store_unit and lsu_load_format.
// Ports:   none (package).

package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_format.sv
// rtl/lsu_load_format.sv - lane select and sign/zero extension of a memory read word
//
// Purpose: extracts the addressed byte/halfword from a 32-bit read word and
//          extends it according to the access size. Purely combinational.
// Ports:
//   rd_word_i  in  32  raw word returned by data memory
//   addr_lo_i  in   2  byte offset within the word
//   size_i     in   3  access size code (B/H/W/BU/HU, others behave as W)
//   data_o     out 32  formatted load result

module lsu_load_format
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rd_word_i[7:0];
        case (addr_lo_i)
            2'd0: w_byte = rd_word_i[7:0];
            2'd1: w_byte = rd_word_i[15:8];
            2'd2: w_byte = rd_word_i[23:16];
            2'd3: w_byte = rd_word_i[31:24];
            default: w_byte = rd_word_i[7:0];
        endcase

        // Halfwords are only legal at offsets 0 and 2, so bit 1 picks the lane.
        w_half = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

        case (size_i)
            LDST_B:  data_o = {{24{w_byte[7]}}, w_byte};
            LDST_BU: data_o = {24'h000000, w_byte};
            LDST_H:  data_o = {{16{w_half[15]}}, w_half};
            LDST_HU: data_o = {16'h0000, w_half};
            default: data_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core-side data memory responder with stall, byte enables and load formatting
//
// Purpose: accepts a load/store from the core, stalls the core until the data
//          memory completes (or the access is rejected as misaligned or times
//          out), drives word-aligned byte-enabled memory requests and returns
//          formatted load data.
// Ports:
//   clk_i         in   1   clock
//   rst_i         in   1   synchronous active-high reset
//   core_req_i    in   1   core access request
//   core_we_i     in   1   1 = store, 0 = load
//   core_size_i   in   3   access size code
//   core_addr_i   in  32   byte address
//   core_wd_i     in  32   store data
//   core_rd_o     out 32   formatted load data (completion cycle only)
//   core_stall_o  out  1   core must hold
//   err_o         out  1   misaligned or timed-out completion
//   mem_req_o     out  1   memory request
//   mem_we_o      out  1   memory write enable
//   mem_be_o      out  4   memory byte enables
//   mem_addr_o    out 32   word-aligned memory address
//   mem_wd_o      out 32   lane-replicated store data
//   mem_rd_i      in  32   memory read data
//   mem_ready_i   in   1   memory completes access

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       r_state;
    lsu_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic        w_in_wait;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_done;
    logic        w_load_ok;
    logic [31:0] w_fmt_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_misaligned = 1'b0;
        case (core_size_i)
            LDST_H, LDST_HU: w_misaligned = core_addr_i[0];
            LDST_W:          w_misaligned = (core_addr_i[1:0] != 2'b00);
            default:         w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        w_in_wait    = (r_state == WAIT);
        w_timeout    = w_in_wait && (r_cnt == CNT_LAST);
        w_done       = w_in_wait && (mem_ready_i || w_timeout || w_misaligned);
        core_stall_o = core_req_i && !w_done;
        // A ready arriving together with the timeout still counts as success;
        // a misaligned access never reached memory, so its ready is meaningless.
        err_o        = w_done && (w_misaligned || !mem_ready_i);
        w_load_ok    = w_in_wait && core_req_i && mem_ready_i && !w_misaligned && !core_we_i;

        w_next_state = r_state;
        w_next_cnt   = '0;
        case (r_state)
            IDLE: begin
                if (core_req_i) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (w_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_be_o = 4'b1111;
        mem_wd_o = core_wd_i;
        case (core_size_i)
            LDST_B, LDST_BU: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
        endcase
    end

    assign mem_req_o  = core_req_i && w_in_wait && !w_misaligned;
    assign mem_we_o   = core_we_i;
    assign mem_addr_o = {core_addr_i[31:2], 2'b00};

    lsu_load_format u_load_format (
        .rd_word_i (mem_rd_i),
        .addr_lo_i (core_addr_i[1:0]),
        .size_i    (core_size_i),
        .data_o    (w_fmt_data)
    );

    assign core_rd_o = w_load_ok ? w_fmt_data : 32'h0;

endmodule
